// File: rtl/fpsr_task_sequencer.sv
// fpsr_task_sequencer: debounced confirm button drives a quiz/game task FSM with score and wrong counters.
// Optional game timeout is built only when FPSR_TASK_TIMEOUT_EN is defined.
module fpsr_task_sequencer #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1000000000,
    parameter logic [3:0]  Q1_KEY = 4'h3,
    parameter logic [3:0]  Q2_KEY = 4'hA,
    parameter logic [3:0]  Q3_KEY = 4'h5,
    parameter logic [7:0]  G1_KEY = 8'h0F,
    parameter logic [7:0]  G2_KEY = 8'hA5,
    parameter logic [7:0]  G3_KEY = 8'hF0
) (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic        door,
    input  logic        seat,
    input  logic        btn_confirm,
    input  logic [7:0]  sw,
    output logic        q_Q1,
    output logic        q_Q2,
    output logic        q_Q3,
    output logic        q_G1,
    output logic        q_G2,
    output logic        q_G3,
    output logic [15:0] score,
    output logic [7:0]  wrong_cnt,
    output logic        done,
    output logic        timeout
);
    typedef enum logic [3:0] {S_IDLE, S_Q1, S_Q2, S_Q3, S_WAIT_DOOR, S_G1, S_G2, S_G3, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_sync;
    logic [19:0] r_db_cnt;
    logic        r_armed, r_press;
    logic        w_good, w_bad, w_expire, w_in_g;
    logic [3:0]  w_qkey;
    logic [7:0]  w_gkey;

    // Armed: count consecutive high clocks; disarmed: count consecutive low clocks to re-arm.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_sync   <= 2'b00;
            r_db_cnt <= '0;
            r_armed  <= 1'b1;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn_confirm};
            r_press <= 1'b0;
            if (r_sync[1] != r_armed)
                r_db_cnt <= '0;
            else if (r_db_cnt == DEBOUNCE_CYCLES - 20'd1) begin
                r_db_cnt <= '0;
                r_armed  <= ~r_armed;
                r_press  <= r_armed;
            end else
                r_db_cnt <= r_db_cnt + 20'd1;
        end
    end

    assign w_in_g = (r_state == S_G1) || (r_state == S_G2) || (r_state == S_G3);
    assign w_qkey = (r_state == S_Q1) ? Q1_KEY : (r_state == S_Q2) ? Q2_KEY : Q3_KEY;
    assign w_gkey = (r_state == S_G1) ? G1_KEY : (r_state == S_G2) ? G2_KEY : G3_KEY;

    // Qn and Gn states are consecutive in the encoding, so a correct answer steps to the next code.
    always_comb begin
        w_next = r_state;
        w_good = 1'b0;
        w_bad  = 1'b0;
        if (r_press) begin
            case (r_state)
                S_IDLE:               if (seat) w_next = S_Q1;
                S_Q1, S_Q2, S_Q3: begin
                    w_good = (sw[3:0] == w_qkey);
                    w_bad  = ~w_good;
                end
                S_WAIT_DOOR:          if (door) w_next = S_G1;
                S_G1, S_G2, S_G3: begin
                    w_good = (sw == w_gkey);
                    w_bad  = ~w_good;
                end
                default: ;
            endcase
        end
        if (w_good)
            w_next = state_t'(r_state + 4'd1);
        else if (w_expire)
            w_next = S_WAIT_DOOR;
    end

`ifdef FPSR_TASK_TIMEOUT_EN
    logic [31:0] r_to_cnt;

    assign w_expire = w_in_g && (r_to_cnt == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_to_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            r_to_cnt <= (w_next != r_state) ? 32'd0 : w_in_g ? r_to_cnt + 32'd1 : r_to_cnt;
            if (w_expire && !w_good)
                timeout <= 1'b1;
            else if (r_press)
                timeout <= 1'b0;
        end
    end
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            q_Q1      <= 1'b0;
            q_Q2      <= 1'b0;
            q_Q3      <= 1'b0;
            q_G1      <= 1'b0;
            q_G2      <= 1'b0;
            q_G3      <= 1'b0;
            done      <= 1'b0;
            score     <= '0;
            wrong_cnt <= '0;
        end else begin
            r_state <= w_next;
            q_Q1    <= (w_next == S_Q1);
            q_Q2    <= (w_next == S_Q2);
            q_Q3    <= (w_next == S_Q3);
            q_G1    <= (w_next == S_G1);
            q_G2    <= (w_next == S_G2);
            q_G3    <= (w_next == S_G3);
            done    <= (w_next == S_DONE);
            if (w_good && score != 16'hFFFF)
                score <= score + 16'd1;
            if (w_bad && wrong_cnt != 8'hFF)
                wrong_cnt <= wrong_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_fpsr_task_sequencer.sv
// tb_fpsr_task_sequencer: directed presses with a queued scoreboard of hand-computed output snapshots.
module tb_fpsr_task_sequencer;
    logic        ClkPort = 1'b0;
    logic        Reset, door, seat, btn_confirm;
    logic [7:0]  sw;
    logic        q_Q1, q_Q2, q_Q3, q_G1, q_G2, q_G3, done, timeout;
    logic [15:0] score;
    logic [7:0]  wrong_cnt;
    int          checks = 0, errors = 0;

    typedef struct {
        string       name;
        logic [5:0]  q;
        logic [15:0] sc;
        logic [7:0]  wr;
        logic        d;
        logic        t;
    } exp_t;
    exp_t exp_q[$];

`ifdef FPSR_TASK_TIMEOUT_EN
    localparam int TO = 1;
`else
    localparam int TO = 0;
`endif

    fpsr_task_sequencer #(.DEBOUNCE_CYCLES(20'd4), .TIMEOUT_CYCLES(32'd100)) dut (
        .ClkPort(ClkPort), .Reset(Reset), .door(door), .seat(seat), .btn_confirm(btn_confirm), .sw(sw),
        .q_Q1(q_Q1), .q_Q2(q_Q2), .q_Q3(q_Q3), .q_G1(q_G1), .q_G2(q_G2), .q_G3(q_G3),
        .score(score), .wrong_cnt(wrong_cnt), .done(done), .timeout(timeout)
    );

    always #5 ClkPort = ~ClkPort;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [5:0] gq;
        forever begin
            wait (exp_q.size() != 0);
            #1;
            e  = exp_q.pop_front();
            gq = {q_Q1, q_Q2, q_Q3, q_G1, q_G2, q_G3};
            checks++;
            if ({gq, score, wrong_cnt, done, timeout} !== {e.q, e.sc, e.wr, e.d, e.t}) begin
                errors++;
                $display("FAIL %s: got q=%b score=%0d wrong=%0d done=%b timeout=%b, required q=%b score=%0d wrong=%0d done=%b timeout=%b",
                         e.name, gq, score, wrong_cnt, done, timeout, e.q, e.sc, e.wr, e.d, e.t);
            end
        end
    end

    task automatic chk(input string n, input logic [5:0] q, input int sc, input int wr, input logic d, input logic t);
        exp_t e;
        e = '{name: n, q: q, sc: 16'(sc), wr: 8'(wr), d: d, t: t};
        exp_q.push_back(e);
        #2;
    endtask

    task automatic press(input logic [7:0] s);
        sw = s;
        btn_confirm = 1'b1;
        repeat (8) @(negedge ClkPort);
        btn_confirm = 1'b0;
        repeat (8) @(negedge ClkPort);
    endtask

    initial begin
        Reset = 1'b1; door = 1'b0; seat = 1'b0; btn_confirm = 1'b0; sw = 8'h00;
        repeat (3) @(negedge ClkPort);
        chk("in_reset", 6'b000000, 0, 0, 0, 0);
        Reset = 1'b0;
        @(negedge ClkPort);
        chk("reset_release", 6'b000000, 0, 0, 0, 0);
        btn_confirm = 1'b1;
        repeat (3) @(negedge ClkPort);
        btn_confirm = 1'b0;
        repeat (10) @(negedge ClkPort);
        chk("short_glitch", 6'b000000, 0, 0, 0, 0);
        press(8'h00);
        chk("press_no_seat", 6'b000000, 0, 0, 0, 0);
        seat = 1'b1; sw = 8'h00; btn_confirm = 1'b1;
        repeat (10) @(negedge ClkPort);
        btn_confirm = 1'b0;
        repeat (8) @(negedge ClkPort);
        seat = 1'b0;
        chk("enter_q1_long_hold", 6'b100000, 0, 0, 0, 0);
        press(8'h07); chk("q1_wrong", 6'b100000, 0, 1, 0, 0);
        press(8'h03); chk("q1_right", 6'b010000, 1, 1, 0, 0);
        press(8'h0A); chk("q2_right", 6'b001000, 2, 1, 0, 0);
        press(8'h05); chk("q3_right", 6'b000000, 3, 1, 0, 0);
        press(8'h00); chk("wait_no_door", 6'b000000, 3, 1, 0, 0);
        door = 1'b1;
        press(8'h00); chk("enter_g1", 6'b000100, 3, 1, 0, 0);
        press(8'h00); chk("g1_wrong", 6'b000100, 3, 2, 0, 0);
        press(8'h0F); chk("g1_right", 6'b000010, 4, 2, 0, 0);
`ifdef FPSR_TASK_TIMEOUT_EN
        repeat (100) @(negedge ClkPort);
        chk("g2_timeout", 6'b000000, 4, 2, 0, 1);
        press(8'h00); chk("reenter_g1", 6'b000100, 4, 2, 0, 0);
        press(8'h0F); chk("g1_right_again", 6'b000010, 5, 2, 0, 0);
`endif
        press(8'hA5); chk("g2_right", 6'b000001, 5 + TO, 2, 0, 0);
        #1 Reset = 1'b1;
        chk("reset_in_g3", 6'b000000, 0, 0, 0, 0);
        @(negedge ClkPort);
        Reset = 1'b0;
        @(negedge ClkPort);
        chk("idle_after_reset", 6'b000000, 0, 0, 0, 0);
        seat = 1'b1;
        press(8'h00); chk("run_q1", 6'b100000, 0, 0, 0, 0);
        press(8'h03);
        press(8'h0A);
        press(8'h05); chk("run_wait_door", 6'b000000, 3, 0, 0, 0);
        press(8'h00); chk("run_g1", 6'b000100, 3, 0, 0, 0);
        press(8'h0F);
        press(8'hA5); chk("run_g3", 6'b000001, 5, 0, 0, 0);
        press(8'hF0); chk("run_done", 6'b000000, 6, 0, 1, 0);
        press(8'h00); chk("done_hold", 6'b000000, 6, 0, 1, 0);
        repeat (2) @(negedge ClkPort);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
